fifo_modal: RTL and testbench
=============================

// Module: fifo_modal
// PURPOSE
//   Synchronous single-clock FIFO. Width, depth and output mode are chosen by
//   parameters, so no `ifdef-selected variants are needed. Used as the generic
//   valid/ready buffer between streaming blocks.
//   Mode FWFT=1: first-word-fall-through. Mode FWFT=0: registered output.
// PARAMETERS
//   WIDTH       8   data width in bits, >=1
//   DEPTH       16  total capacity in entries; power of 2, >=2
//   FWFT        1   1: head visible combinationally from storage; 0: registered output
//   RESET_DATA  '0  value of o_rd_data after reset and after clear (WIDTH bits)
// PORTS
//   i_clk       in   1                  clock, rising edge
//   i_arst_n    in   1                  asynchronous reset, active low
//   i_clr       in   1                  synchronous flush
//   i_wr_valid  in   1                  write request
//   o_wr_ready  out  1                  space available
//   i_wr_data   in   WIDTH              write data
//   o_rd_valid  out  1                  head entry available
//   i_rd_ready  in   1                  consumer accepts head
//   o_rd_data   out  WIDTH              head data
//   o_nEntries  out  $clog2(DEPTH+1)    current occupancy, 0..DEPTH
// BEHAVIOUR
//   Interface: one clock (i_clk); reset is asynchronous and active-low (i_arst_n).
//   Reset: all pointers and counts are 0. o_wr_ready=1, o_rd_valid=0,
//     o_rd_data=RESET_DATA, o_nEntries=0.
//   Write: accepted when i_wr_valid&&o_wr_ready at a rising edge.
//     o_wr_ready = (o_nEntries != DEPTH).
//   Read: pops when o_rd_valid&&i_rd_ready at a rising edge.
//     o_rd_valid = (o_nEntries != 0).
//   Data must be held stable while o_rd_valid=1 and no pop has occurred.
//   Order: strict FIFO, no loss, no duplication.
//   Occupancy: o_nEntries is +1 on a write only, -1 on a pop only,
//     unchanged when both or neither occur. It counts storage entries plus the
//     output register (FWFT=0), so capacity is DEPTH in both modes.
//   Full: o_wr_ready=0. A simultaneous pop does NOT enable a write that cycle.
//   Empty: o_rd_valid=0. No same-cycle write->read bypass.
//   Latency, write accepted at edge k into an empty FIFO:
//     FWFT=1 -> o_rd_valid=1 after edge k.
//     FWFT=0 -> o_rd_valid=1 after edge k+1.
//   FWFT=0: o_rd_data is driven only from a flop. The flop is refilled from
//     storage on the edge it is emptied or found empty, so streaming throughput
//     is 1/cycle after the initial fill.
//   Pointers: log2(DEPTH)-bit, wrap naturally from DEPTH-1 to 0. Full and empty
//     are decided from o_nEntries, never from pointer equality.
//   i_clr: highest priority. On that edge: counts and pointers = 0,
//     o_rd_data=RESET_DATA, and any write or read in the same cycle is discarded.
//   Reset mid-operation: asserting i_arst_n=0 forces the reset state immediately;
//     contents are lost. The first accepted write after deassertion is the new head.
//   Storage contents are not reset. No X may reach o_rd_data while o_rd_valid=1.
// STRUCTURE
//   Package fifo_modal_pkg: function for occupancy width
//     ($clog2(DEPTH+1)), elaboration assertion helpers for the DEPTH
//     power-of-2 check.
//   Sub-module fifo_modal_mem: WIDTH x DEPTH array, one write port and one
//     asynchronous read port. Top level holds pointers, counter, output flop
//     and mode generate blocks.
//   Mode selection is by generate-if on FWFT only. No `ifdef.
// TESTING
//   Run every case for FWFT in {0,1}, WIDTH=8, DEPTH=4.
//   1 Reset, then idle -> o_wr_ready=1, o_rd_valid=0, o_rd_data=RESET_DATA, o_nEntries=0.
//   2 Write 0x11 with i_rd_ready=0 -> o_rd_valid rises 1 cycle (FWFT=1) or
//     2 cycles (FWFT=0) later, data=0x11.
//   3 Write 0xA0..0xA3 -> o_nEntries=4, o_wr_ready=0. Extra write of 0xFF is
//     refused. Drain -> A0,A1,A2,A3 in order, 0xFF never appears.
//   4 Full, pop and write in the same cycle -> write refused, o_nEntries=3.
//   5 Continuous write+read of 0..19 -> wraps pointers 5x, output 0..19 in order.
//     After fill, throughput is 1/cycle.
//   6 i_clr with 2 entries and simultaneous write -> o_nEntries=0, o_rd_valid=0.
//     Repeat with i_arst_n pulsed mid-stream -> reset values, no stale data after.

Source files
------------

// File: rtl/fifo_modal_pkg.sv
// Shared helpers for fifo_modal: occupancy counter width and DEPTH sanity check.
package fifo_modal_pkg;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_modal_mem.sv
// WIDTH x DEPTH storage array: one synchronous write port, one asynchronous read port.
module fifo_modal_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  // Contents are deliberately not reset; readers only look at written entries.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/fifo_modal.sv
// Single-clock valid/ready FIFO; FWFT selects fall-through or registered-output head.
module fifo_modal
  import fifo_modal_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DEPTH      = 16,
  parameter bit               FWFT       = 1'b1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                            i_clk,
  input  logic                            i_arst_n,
  input  logic                            i_clr,
  input  logic                            i_wr_valid,
  output logic                            o_wr_ready,
  input  logic [WIDTH-1:0]                i_wr_data,
  output logic                            o_rd_valid,
  input  logic                            i_rd_ready,
  output logic [WIDTH-1:0]                o_rd_data,
  output logic [occ_width(DEPTH)-1:0]     o_nEntries
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = occ_width(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("fifo_modal: DEPTH must be a power of 2 and >= 2");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_fire;
  logic             rd_fire;
  logic             mem_rd;
  logic [WIDTH-1:0] mem_rdata;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; full/empty come from the counter only, never pointer equality.
  assign o_wr_ready = (cnt_q != CW'(DEPTH));
  assign wr_fire    = i_wr_valid && o_wr_ready;
  assign o_nEntries = cnt_q;

  fifo_modal_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (wr_fire && !i_clr),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_wr_data),
    .i_raddr (rd_ptr_q),
    .o_rdata (mem_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (i_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(wr_fire);
      rd_ptr_d = rd_ptr_q + PW'(mem_rd);
      unique case ({wr_fire, rd_fire})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  if (FWFT) begin : g_fwft
    assign o_rd_valid = (cnt_q != '0);
    assign rd_fire    = o_rd_valid && i_rd_ready;
    assign mem_rd     = rd_fire;
    // Mask the unwritten array while empty so reset/clear show RESET_DATA.
    assign o_rd_data  = o_rd_valid ? mem_rdata : RESET_DATA;
  end else begin : g_reg
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [CW-1:0]    st_cnt;

    // cnt_q includes the output flop, so storage holds the remainder.
    assign st_cnt     = cnt_q - CW'(out_valid_q);
    assign rd_fire    = out_valid_q && i_rd_ready;
    assign mem_rd     = (!out_valid_q || rd_fire) && (st_cnt != '0);
    assign o_rd_valid = out_valid_q;
    assign o_rd_data  = out_q;

    always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (i_clr) begin
        out_d       = RESET_DATA;
        out_valid_d = 1'b0;
      end else if (mem_rd) begin
        out_d       = mem_rdata;
        out_valid_d = 1'b1;
      end else if (rd_fire) begin
        out_valid_d = 1'b0;
      end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        out_q       <= RESET_DATA;
        out_valid_q <= 1'b0;
      end else begin
        out_q       <= out_d;
        out_valid_q <= out_valid_d;
      end
    end
  end

endmodule

// File: tb/tb_fifo_modal.sv
// Directed bench for fifo_modal: every case runs on a FWFT=0 and a FWFT=1 instance.
module tb_fifo_modal;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam logic [7:0]  RD = 8'h5A;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic arst_n;

  logic       clr      [2];
  logic       wr_valid [2];
  logic       rd_ready [2];
  logic [7:0] wr_data  [2];

  logic       wr_ready0, rd_valid0, wr_ready1, rd_valid1;
  logic [7:0] rd_data0, rd_data1;
  logic [2:0] n0, n1;

  int mode;
  logic       o_wr_ready, o_rd_valid;
  logic [7:0] o_rd_data;
  logic [2:0] o_n;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  fifo_modal #(.WIDTH(W), .DEPTH(D), .FWFT(1'b0), .RESET_DATA(RD)) u_reg (
    .i_clk(clk), .i_arst_n(arst_n), .i_clr(clr[0]),
    .i_wr_valid(wr_valid[0]), .o_wr_ready(wr_ready0), .i_wr_data(wr_data[0]),
    .o_rd_valid(rd_valid0), .i_rd_ready(rd_ready[0]), .o_rd_data(rd_data0),
    .o_nEntries(n0)
  );

  fifo_modal #(.WIDTH(W), .DEPTH(D), .FWFT(1'b1), .RESET_DATA(RD)) u_fwft (
    .i_clk(clk), .i_arst_n(arst_n), .i_clr(clr[1]),
    .i_wr_valid(wr_valid[1]), .o_wr_ready(wr_ready1), .i_wr_data(wr_data[1]),
    .o_rd_valid(rd_valid1), .i_rd_ready(rd_ready[1]), .o_rd_data(rd_data1),
    .o_nEntries(n1)
  );

  always_comb begin
    o_wr_ready = (mode == 1) ? wr_ready1 : wr_ready0;
    o_rd_valid = (mode == 1) ? rd_valid1 : rd_valid0;
    o_rd_data  = (mode == 1) ? rd_data1  : rd_data0;
    o_n        = (mode == 1) ? n1        : n0;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_valid[mode] = 1'b1;
    wr_data[mode]  = d;
    tick();
    wr_valid[mode] = 1'b0;
  endtask

  task automatic pop();
    rd_ready[mode] = 1'b1;
    tick();
    rd_ready[mode] = 1'b0;
  endtask

  // scoreboard checks
  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s mode=%0d observed=%0h expected=%0h", tag, mode, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s mode=%0d observed=%0b expected=%0b", tag, mode, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input logic [2:0] exp);
    n_cmp++;
    assert (o_n === exp) else begin
      n_err++;
      $error("FAIL %s mode=%0d observed=%0d expected=%0d", tag, mode, o_n, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk1({tag, "_wr_ready"}, o_wr_ready, 1'b1);
    chk1({tag, "_rd_valid"}, o_rd_valid, 1'b0);
    chk8({tag, "_rd_data"}, o_rd_data, RD);
    chk_n({tag, "_n"}, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    mode   = 0;
    arst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clr[i] = 1'b0; wr_valid[i] = 1'b0; rd_ready[i] = 1'b0; wr_data[i] = '0;
    end

    for (int m = 0; m < 2; m++) begin
      mode   = m;
      arst_n = 1'b0;
      tick();
      tick();
      arst_n = 1'b1;
      tick();

      // 1: reset then idle
      chk_reset_state("c1_reset");

      // 2: single write latency
      push(8'h11);
      chk_n("c2_n_after_write", 3'd1);
      if (mode == 0) begin
        chk1("c2_not_yet_valid", o_rd_valid, 1'b0);
        tick();
      end
      chk1("c2_valid", o_rd_valid, 1'b1);
      chk8("c2_data", o_rd_data, 8'h11);
      pop();
      chk_n("c2_n_after_pop", 3'd0);
      chk1("c2_empty", o_rd_valid, 1'b0);

      // 3: fill to full, refused extra write, ordered drain
      wr_valid[mode] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        wr_data[mode] = 8'hA0 + 8'(i);
        tick();
      end
      wr_data[mode] = 8'hFF;
      chk_n("c3_full_n", 3'd4);
      chk1("c3_full_wr_ready", o_wr_ready, 1'b0);
      tick();
      wr_valid[mode] = 1'b0;
      chk_n("c3_refused_n", 3'd4);
      rd_ready[mode] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        chk1("c3_drain_valid", o_rd_valid, 1'b1);
        chk8("c3_drain_data", o_rd_data, 8'hA0 + 8'(i));
        tick();
      end
      rd_ready[mode] = 1'b0;
      chk1("c3_drained_valid", o_rd_valid, 1'b0);
      chk_n("c3_drained_n", 3'd0);

      // 4: full with simultaneous pop and write
      wr_valid[mode] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        wr_data[mode] = 8'h30 + 8'(i);
        tick();
      end
      wr_data[mode]  = 8'hEE;
      rd_ready[mode] = 1'b1;
      chk1("c4_full_wr_ready", o_wr_ready, 1'b0);
      tick();
      wr_valid[mode] = 1'b0;
      chk_n("c4_n", 3'd3);
      chk1("c4_wr_ready", o_wr_ready, 1'b1);
      for (int i = 1; i < 4; i++) begin
        chk8("c4_drain_data", o_rd_data, 8'h30 + 8'(i));
        tick();
      end
      rd_ready[mode] = 1'b0;
      chk_n("c4_drained_n", 3'd0);
      chk1("c4_no_ee", o_rd_valid, 1'b0);

      // 5: streaming 0..19 with scoreboard
      begin
        int w;
        int got;
        int first;
        int last;
        logic do_wr;
        w = 0; got = 0; first = -1; last = -1;
        exp_q.delete();
        rd_ready[mode] = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 20; cyc++) begin
          wr_valid[mode] = (w < 20);
          wr_data[mode]  = 8'(w);
          do_wr = wr_valid[mode] && o_wr_ready;
          if (o_rd_valid) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_err++;
              $error("FAIL c5_unexpected mode=%0d observed=%0h expected=none", mode, o_rd_data);
            end else begin
              chk8("c5_stream_data", o_rd_data, exp_q.pop_front());
            end
            got++;
            if (first < 0) first = cyc;
            last = cyc;
          end
          if (do_wr) begin
            exp_q.push_back(8'(w));
            w++;
          end
          tick();
        end
        wr_valid[mode] = 1'b0;
        rd_ready[mode] = 1'b0;
        chk8("c5_count", 8'(got), 8'd20);
        chk8("c5_back_to_back", 8'(last - first), 8'd19);
        chk_n("c5_final_n", 3'd0);
      end

      // 6a: clear with two entries and a simultaneous write
      push(8'h61);
      push(8'h62);
      chk_n("c6_pre_clr_n", 3'd2);
      clr[mode]      = 1'b1;
      wr_valid[mode] = 1'b1;
      wr_data[mode]  = 8'h63;
      rd_ready[mode] = 1'b1;
      tick();
      clr[mode]      = 1'b0;
      wr_valid[mode] = 1'b0;
      rd_ready[mode] = 1'b0;
      chk_reset_state("c6_clr");
      tick();
      chk1("c6_clr_no_write", o_rd_valid, 1'b0);
      push(8'h64);
      if (mode == 0) tick();
      chk1("c6_post_clr_valid", o_rd_valid, 1'b1);
      chk8("c6_post_clr_data", o_rd_data, 8'h64);
      pop();
      chk_n("c6_post_clr_n", 3'd0);

      // 6b: asynchronous reset mid-stream
      push(8'h71);
      push(8'h72);
      push(8'h73);
      #3;
      arst_n = 1'b0;
      #1;
      chk_reset_state("c6_async_rst");
      tick();
      arst_n = 1'b1;
      tick();
      chk_reset_state("c6_after_rst");
      push(8'h81);
      if (mode == 0) tick();
      chk1("c6_post_rst_valid", o_rd_valid, 1'b1);
      chk8("c6_post_rst_data", o_rd_data, 8'h81);
      chk_n("c6_post_rst_n", 3'd1);
      pop();
      chk_n("c6_post_rst_drained", 3'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
